// File: rtl/decode_sequencer.sv
// Control sequencer for the output-layer argmax datapath: loads confidences, scans
// every class, captures the winning digit and presents it on a valid/ready handshake.
module decode_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4,
  parameter int CONF_W      = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              network_done,
  input  logic [CONF_W-1:0] conf_threshold,
  input  logic [IDX_W-1:0]  dp_digit,
  input  logic [CONF_W-1:0] dp_max,
  output logic              weight_load,
  output logic              scan_clear,
  output logic              scan_en,
  output logic [IDX_W-1:0]  scan_index,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IDX_W-1:0]  result_digit,
  output logic              result_reject,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SCAN    = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_PRESENT = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [2:0]       state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             pending, pending_nxt;
  logic             overrun_r, overrun_nxt;
  logic [IDX_W-1:0] digit_r;
  logic             reject_r;
  logic             handshake;

  assign handshake = (state == S_PRESENT) && result_ready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    overrun_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (network_done) state_nxt = S_LOAD;
      end
      S_LOAD, S_SCAN, S_SETTLE: begin
        if (network_done) begin
          // A new frame aborts the in-flight job; its result is never presented.
          state_nxt   = S_LOAD;
          cnt_nxt     = '0;
          overrun_nxt = 1'b1;
        end else if (state == S_LOAD) begin
          state_nxt = S_SCAN;
          cnt_nxt   = '0;
        end else if (state == S_SCAN) begin
          if (cnt == LAST_IDX) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (network_done && pending) overrun_nxt = 1'b1;
        if (handshake) begin
          state_nxt   = (pending || network_done) ? S_LOAD : S_IDLE;
          pending_nxt = 1'b0;
          cnt_nxt     = '0;
        end else if (network_done) begin
          pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      overrun_r <= 1'b0;
      digit_r   <= '0;
      reject_r  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      overrun_r <= overrun_nxt;
      // The datapath's final compare has landed by SETTLE; capture unless aborted.
      if (state == S_SETTLE && !network_done) begin
        digit_r  <= dp_digit;
        reject_r <= (dp_max < conf_threshold);
      end
    end
  end

  assign weight_load   = (state == S_LOAD);
  assign scan_clear    = (state == S_LOAD);
  assign scan_en       = (state == S_SCAN);
  assign scan_index    = (state == S_SCAN) ? cnt : '0;
  assign result_valid  = (state == S_PRESENT);
  assign busy          = (state == S_LOAD) || (state == S_SCAN) || (state == S_SETTLE);
  assign overrun       = overrun_r;
  assign result_digit  = digit_r;
  assign result_reject = reject_r;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: table of full jobs plus hand-written
// sequences for backpressure, abort, merge and reset corner cases.
module tb_decode_sequencer;

  localparam int NC = 10;
  localparam int IW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          network_done;
  logic [CW-1:0] conf_threshold;
  logic [IW-1:0] dp_digit;
  logic [CW-1:0] dp_max;
  logic          weight_load;
  logic          scan_clear;
  logic          scan_en;
  logic [IW-1:0] scan_index;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_digit;
  logic          result_reject;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_sequencer #(.NUM_CLASSES(NC), .IDX_W(IW), .CONF_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .network_done(network_done),
    .conf_threshold(conf_threshold), .dp_digit(dp_digit), .dp_max(dp_max),
    .weight_load(weight_load), .scan_clear(scan_clear), .scan_en(scan_en),
    .scan_index(scan_index), .result_valid(result_valid), .result_ready(result_ready),
    .result_digit(result_digit), .result_reject(result_reject), .busy(busy),
    .overrun(overrun)
  );

  typedef struct {
    logic [IW-1:0] dig;
    logic [CW-1:0] mx;
    logic [CW-1:0] thr;
    logic          rej;
  } vec_t;

  vec_t vt[6];

  logic [9:0] ctl;
  assign ctl = {weight_load, scan_clear, scan_en, scan_index, result_valid, busy, overrun};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected control bundle: st 0=IDLE 1=LOAD 2=SCAN 3=SETTLE 4=PRESENT
  function automatic logic [9:0] ctl_exp(input int st, input int idx, input logic ovr);
    logic [9:0] v;
    case (st)
      1:       v = {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, ovr};
      2:       v = {1'b0, 1'b0, 1'b1, 4'(idx), 1'b0, 1'b1, ovr};
      3:       v = {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, ovr};
      4:       v = {1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, ovr};
      default: v = {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ovr};
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input int st, input int idx, input logic ovr);
    chk(name, 32'(ctl), 32'(ctl_exp(st, idx, ovr)));
  endtask

  // From LOAD: ten SCAN cycles, SETTLE, then first PRESENT cycle.
  task automatic run_from_load();
    for (int i = 0; i < NC; i++) begin
      tick();
      chk_ctl("scan", 2, i, 1'b0);
    end
    tick();
    chk_ctl("settle", 3, 0, 1'b0);
    tick();
    chk_ctl("present", 4, 0, 1'b0);
  endtask

  task automatic start_job(input logic [IW-1:0] d, input logic [CW-1:0] m, input logic [CW-1:0] t);
    dp_digit       = d;
    dp_max         = m;
    conf_threshold = t;
    network_done   = 1'b1;
    tick();
    network_done   = 1'b0;
    chk_ctl("load", 1, 0, 1'b0);
    run_from_load();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{4'd7, 4'd12, 4'd8,  1'b0};
    vt[1] = '{4'd2, 4'd8,  4'd8,  1'b0};
    vt[2] = '{4'd9, 4'd7,  4'd8,  1'b1};
    vt[3] = '{4'd0, 4'd0,  4'd0,  1'b0};
    vt[4] = '{4'd5, 4'd15, 4'd15, 1'b0};
    vt[5] = '{4'd3, 4'd14, 4'd15, 1'b1};

    n_rst          = 1'b0;
    network_done   = 1'b1;
    result_ready   = 1'b1;
    conf_threshold = '0;
    dp_digit       = '0;
    dp_max         = '0;
    tick();
    tick();
    chk_ctl("reset_ctl", 0, 0, 1'b0);
    chk("reset_digit", 32'(result_digit), 32'd0);
    chk("reset_reject", 32'(result_reject), 32'd0);
    n_rst        = 1'b1;
    network_done = 1'b0;
    tick();
    chk_ctl("idle_after_reset", 0, 0, 1'b0);

    // Table: full jobs with immediate acceptance, including threshold boundaries.
    for (int k = 0; k < 6; k++) begin
      result_ready = 1'b1;
      start_job(vt[k].dig, vt[k].mx, vt[k].thr);
      chk("tbl_digit", 32'(result_digit), 32'(vt[k].dig));
      chk("tbl_reject", 32'(result_reject), 32'(vt[k].rej));
      tick();
      chk_ctl("tbl_idle", 0, 0, 1'b0);
      chk("tbl_digit_hold", 32'(result_digit), 32'(vt[k].dig));
    end

    // Backpressure: valid held 6 cycles, accepted on the 6th.
    result_ready = 1'b0;
    start_job(4'd7, 4'd3, 4'd8);
    chk("bp_digit", 32'(result_digit), 32'd7);
    chk("bp_reject", 32'(result_reject), 32'd1);
    for (int k = 0; k < 5; k++) begin
      dp_digit = 4'd1;
      dp_max   = 4'd15;
      tick();
      chk_ctl("bp_hold", 4, 0, 1'b0);
      chk("bp_digit_hold", 32'(result_digit), 32'd7);
      chk("bp_reject_hold", 32'(result_reject), 32'd1);
    end
    result_ready = 1'b1;
    tick();
    chk_ctl("bp_idle", 0, 0, 1'b0);

    // Abort mid-scan at index 4.
    dp_digit = 4'd4; dp_max = 4'd10; conf_threshold = 4'd5;
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    chk_ctl("ab_load", 1, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_ctl("ab_scan", 2, i, 1'b0);
    end
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    chk_ctl("ab_reload", 1, 0, 1'b1);
    dp_digit = 4'd6;
    run_from_load();
    chk("ab_digit", 32'(result_digit), 32'd6);
    tick();
    chk_ctl("ab_idle", 0, 0, 1'b0);

    // Pending job in PRESENT, then merged overrun.
    result_ready = 1'b0;
    start_job(4'd1, 4'd9, 4'd4);
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    chk_ctl("pend_set", 4, 0, 1'b0);
    tick();
    chk_ctl("pend_wait", 4, 0, 1'b0);
    result_ready = 1'b1;
    dp_digit     = 4'd8;
    tick();
    chk_ctl("pend_load", 1, 0, 1'b0);
    chk("pend_digit_hold", 32'(result_digit), 32'd1);
    result_ready = 1'b0;
    run_from_load();
    chk("pend_digit2", 32'(result_digit), 32'd8);
    network_done = 1'b1;
    tick();
    chk_ctl("merge_first", 4, 0, 1'b0);
    tick();
    network_done = 1'b0;
    chk_ctl("merge_ovr", 4, 0, 1'b1);
    tick();
    chk_ctl("merge_ovr_clr", 4, 0, 1'b0);
    result_ready = 1'b1;
    dp_digit     = 4'd2;
    tick();
    chk_ctl("merge_load", 1, 0, 1'b0);
    run_from_load();
    chk("merge_digit", 32'(result_digit), 32'd2);
    tick();
    chk_ctl("merge_single_job", 0, 0, 1'b0);

    // Reset during SCAN together with network_done.
    dp_digit = 4'd3;
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    tick();
    tick();
    chk_ctl("rs_scan", 2, 1, 1'b0);
    n_rst        = 1'b0;
    network_done = 1'b1;
    tick();
    chk_ctl("rs_ctl", 0, 0, 1'b0);
    chk("rs_digit", 32'(result_digit), 32'd0);
    n_rst        = 1'b1;
    network_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ctl("rs_idle", 0, 0, 1'b0);
    end
    start_job(4'd5, 4'd12, 4'd3);
    chk("rs_digit_new", 32'(result_digit), 32'd5);
    chk("rs_reject_new", 32'(result_reject), 32'd0);
    tick();
    chk_ctl("rs_final_idle", 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Control FSM for the output-layer argmax datapath, which holds the ten 4-bit sigmoid confidences, a running max and a running digit index.
- On each network_done pulse it loads the datapath's weight-hold register and clears the running max/index. It then steps the scan index over every class and captures the final digit and confidence.
- It presents the result on a valid/ready handshake with a low-confidence reject flag. It handles back-to-back and mid-scan network_done events deterministically.

Parameters:
- NUM_CLASSES, 10, number of confidence entries scanned; legal range 2..2**IDX_W.
- IDX_W, 4, width of scan_index and result_digit.
- CONF_W, 4, width of confidence values and threshold.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- network_done  in  1  one-cycle pulse: new sigmoid outputs are valid this cycle.
- conf_threshold  in  CONF_W  minimum acceptable max confidence; sampled in SETTLE.
- dp_digit  in  IDX_W  datapath running argmax index.
- dp_max  in  CONF_W  datapath running max confidence.
- weight_load  out  1  datapath captures the confidences into its hold register.
- scan_clear  out  1  datapath zeroes its running max and index.
- scan_en  out  1  datapath compares entry scan_index and updates its running max.
- scan_index  out  IDX_W  entry currently compared; 0 when scan_en=0.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_digit  out  IDX_W  detected digit.
- result_reject  out  1  1 when captured max < conf_threshold.
- busy  out  1  high in LOAD, SCAN, SETTLE.
- overrun  out  1  one-cycle pulse: a network_done restarted or was merged with a pending job.

Behaviour:
- Reset: on a clk edge with n_rst=0, the block enters IDLE, clears the pending flag and drives every output to 0. network_done in a reset cycle is ignored.
- States: IDLE, LOAD, SCAN, SETTLE, PRESENT. All control outputs are Moore-decoded from registered state and counter.
- IDLE: all outputs 0. network_done=1 -> LOAD.
- LOAD (1 cycle): weight_load=1, scan_clear=1 -> SCAN with index counter=0.
- SCAN: scan_en=1, scan_index=counter, counter +1 per cycle.
  - At counter=NUM_CLASSES-1 -> SETTLE.
  - The counter never exceeds NUM_CLASSES-1; no wrap occurs inside SCAN.
- SETTLE (1 cycle): the datapath's last update has landed.
  - Register result_digit<=dp_digit and result_reject<=(dp_max<conf_threshold), unsigned compare.
  - Next state PRESENT.
- PRESENT: result_valid=1. result_digit and result_reject stay stable until handshake (result_valid & result_ready).
  - On handshake -> LOAD if pending or network_done this cycle, else IDLE. Pending clears on leaving.
- Latency: network_done at edge T gives LOAD at T+1, SCAN T+2..T+NUM_CLASSES+1, SETTLE T+NUM_CLASSES+2, result_valid first high T+NUM_CLASSES+3 (T+13 at default).
- network_done in LOAD/SCAN/SETTLE: abort and go to LOAD next cycle, with overrun=1 for one cycle. The counter resets and no result is produced for the aborted job.
- network_done in PRESENT without handshake: set pending; result is unaffected.
  - If pending is already set: overrun=1; pending stays a single job.
- result_digit and result_reject hold their last values after handshake until the next SETTLE. result_valid is the only qualifier.
- result_ready is ignored outside PRESENT.

Test Plan:
1. Reset, then network_done at T; dp_digit=7, dp_max=12, conf_threshold=8, ready=1 -> weight_load/scan_clear at T+1; scan_index 0..9 on T+2..T+11; result_valid=1 only at T+13 with digit=7, reject=0; IDLE at T+14.
2. Same, with ready=0 for 5 cycles after valid, dp_max=3 -> valid/digit/reject (reject=1) stable 6 cycles; accepted on the 6th; then IDLE.
3. network_done while scan_index=4 -> overrun pulse; weight_load reasserted next cycle; scan restarts at 0; exactly one result_valid, at restart T'+13.
4. network_done in PRESENT with ready=0, then ready=1 two cycles later -> LOAD on the cycle after handshake (no IDLE cycle); second result follows. A third network_done in PRESENT -> overrun pulse, still one pending job.
5. n_rst=0 during SCAN together with network_done -> next edge all outputs 0, IDLE, no result; a fresh network_done after release gives normal latency.
6. Threshold boundary: dp_max=8, threshold=8 -> reject=0; dp_max=7 -> reject=1; threshold=0 with dp_max=0 -> reject=0.
